// File: rtl/reg_f_ctx_ctrl_if.sv
// Control-unit <-> context sequencer bus, including the shared stack RAM address/write-enable.
// The master side is the requester; the slave side is reg_f_ctx_ctrl.
interface reg_f_ctx_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              push_req;
    logic              pop_req;
    logic [ADDR_W-1:0] stk_addr;
    logic              stk_wren;
    logic              restore_en;
    logic              ready;
    logic              done;
    logic [ADDR_W:0]   sp;
    logic              full;
    logic              empty;
    logic              err;
    logic [ADDR_W:0]   high_water;

    modport master (
        output push_req, pop_req,
        input  stk_addr, stk_wren, restore_en, ready, done,
        input  sp, full, empty, err, high_water
    );

    modport slave (
        input  push_req, pop_req,
        output stk_addr, stk_wren, restore_en, ready, done,
        output sp, full, empty, err, high_water
    );
endinterface

// File: rtl/reg_f_ctx_ctrl.sv
// Context save/restore sequencer for the 9-register stack bank; REG_F_CTX_HIGHWATER_EN adds high_water.
// Latency: push 2 cycles to done; pop RD_LAT+1 cycles to restore_en, done one cycle later.
// Backpressure: ready=0 while busy; requests are only sampled in IDLE and must be held until ready.
module reg_f_ctx_ctrl #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_f_ctx_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH     = 2'd1,
        POP_WAIT = 2'd2,
        POP_LOAD = 2'd3
    } state_t;

    localparam logic [1:0]      CNT_INIT = 2'(RD_LAT - 1);
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    generate
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("reg_f_ctx_ctrl: RD_LAT must be 1..3");
        end
    endgenerate

    state_t          state, state_nx;
    logic [1:0]      cnt, cnt_nx;
    logic [ADDR_W:0] sp_q, sp_nx;
    logic            done_q, done_nx;
    logic            err_q, err_nx;
    logic            full, empty;
    logic [ADDR_W-1:0] top_addr;

    assign full     = (sp_q == DEPTH);
    assign empty    = (sp_q == '0);
    assign top_addr = sp_q[ADDR_W-1:0] - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sp_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sp_q   <= sp_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
        end
    end

    // Push has priority over pop; an illegal request only flags err and stays idle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sp_nx    = sp_q;
        done_nx  = 1'b0;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (bus.push_req) begin
                    if (full) err_nx   = 1'b1;
                    else      state_nx = PUSH;
                end else if (bus.pop_req) begin
                    if (empty) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = POP_WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            PUSH: begin
                sp_nx    = sp_q + 1'b1;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            POP_WAIT: begin
                if (cnt == 2'd0) state_nx = POP_LOAD;
                else             cnt_nx   = cnt - 2'd1;
            end
            POP_LOAD: begin
                sp_nx    = sp_q - 1'b1;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address stays on the top frame through POP_LOAD so the RAM output is stable for the restore.
    always_comb begin
        bus.ready      = (state == IDLE);
        bus.stk_wren   = (state == PUSH);
        bus.restore_en = (state == POP_LOAD);
        bus.stk_addr   = sp_q[ADDR_W-1:0];
        if (state == POP_WAIT || state == POP_LOAD) begin
            bus.stk_addr = top_addr;
        end
    end

    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.sp    = sp_q;
    assign bus.full  = full;
    assign bus.empty = empty;

`ifdef REG_F_CTX_HIGHWATER_EN
    logic [ADDR_W:0] hw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_q <= '0;
        end else if (state == PUSH && (sp_q + 1'b1) > hw_q) begin
            hw_q <= sp_q + 1'b1;
        end
    end

    assign bus.high_water = hw_q;
`else
    assign bus.high_water = '0;
`endif

endmodule
